reg_bank_sb: RTL

//  32-entry general-purpose register bank with pending-write scoreboard.

---
 rtl/reg_bank_sb_if.sv | 35 +++
 rtl/reg_bank_sb.sv | 114 +++++++++++
 2 files changed

// File: rtl/reg_bank_sb_if.sv
// ---------------------------------------------------------------------------
// reg_bank_sb_if: bus bundle for the reg_bank_sb register bank.
//   master modport : the pipeline/control side that issues reads, writes and
//                    pending marks and consumes operands and the hazard flag.
//   slave modport  : the register bank itself.
// Signals:
//   rd_addr_a/b  read addresses (rs/rt)       rd_data_a/b  registered read data
//   wr_en/addr/data  write-back               iss_en/iss_addr  mark pending
//   hazard       read targets a pending reg   busy_cnt     number of pending regs
// ---------------------------------------------------------------------------
interface reg_bank_sb_if #(
    parameter int unsigned DATA_W = 32
);
    logic [4:0]        rd_addr_a;
    logic [4:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              iss_en;
    logic [4:0]        iss_addr;
    logic              hazard;
    logic [5:0]        busy_cnt;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data_a, rd_data_b, hazard, busy_cnt
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data_a, rd_data_b, hazard, busy_cnt
    );
endinterface

// File: rtl/reg_bank_sb.sv
// ---------------------------------------------------------------------------
// reg_bank_sb: 32-entry register bank with a pending-write scoreboard.
//   - Two registered read ports (latency 1), r0 hard-wired to zero.
//   - One write-back port; a write to a pending register retires it.
//   - iss_en marks a destination pending; hazard flags reads of pending regs.
//   - busy_cnt tracks the number of pending registers (0..31).
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      reg_bank_sb_if.slave (see interface file for signal list)
// Configuration:
//   REG_BYPASS_EN  when defined, a same-cycle write is forwarded to a read of the
//                  same address, and hazard ignores a register being retired by
//                  this cycle's write. Undefined: reads see pre-write contents and
//                  hazard reflects pre-edge busy bits only.
// ---------------------------------------------------------------------------
module reg_bank_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input logic          clk,
    input logic          reset_n,
    reg_bank_sb_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;

    logic wr_ok, iss_ok, same_addr, wr_clr, iss_new;
    logic haz_a, haz_b;

    always_comb begin
        wr_ok     = bus.wr_en && (bus.wr_addr != 5'd0);
        iss_ok    = bus.iss_en && (bus.iss_addr != 5'd0);
        same_addr = bus.wr_addr == bus.iss_addr;
        // A write retires a pending bit unless a new issue re-arms it this cycle.
        wr_clr    = wr_ok && busy_q[bus.wr_addr] && !(iss_ok && same_addr);
        iss_new   = iss_ok && !busy_q[bus.iss_addr];
    end

    // Scoreboard next state: issue wins over write on the same address.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
        cnt_d = cnt_q + {5'd0, iss_new} - {5'd0, wr_clr};
    end

    always_comb begin
        rd_a_d = '0;
        rd_b_d = '0;
        if (bus.rd_addr_a != 5'd0) begin
            rd_a_d = regs_q[bus.rd_addr_a];
`ifdef REG_BYPASS_EN
            if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
                rd_a_d = bus.wr_data;
            end
`endif
        end
        if (bus.rd_addr_b != 5'd0) begin
            rd_b_d = regs_q[bus.rd_addr_b];
`ifdef REG_BYPASS_EN
            if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
                rd_b_d = bus.wr_data;
            end
`endif
        end
    end

    always_comb begin
        haz_a = (bus.rd_addr_a != 5'd0) && busy_q[bus.rd_addr_a];
        haz_b = (bus.rd_addr_b != 5'd0) && busy_q[bus.rd_addr_b];
`ifdef REG_BYPASS_EN
        if (wr_clr && (bus.wr_addr == bus.rd_addr_a)) begin
            haz_a = 1'b0;
        end
        if (wr_clr && (bus.wr_addr == bus.rd_addr_b)) begin
            haz_b = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign bus.rd_data_a = rd_a_q;
    assign bus.rd_data_b = rd_b_q;
    assign bus.busy_cnt  = cnt_q;
    assign bus.hazard    = haz_a || haz_b;

endmodule
